// File: rtl/ram1_arbiter.sv
// ram1_arbiter
//   Two-requester round-robin front end for a single-port 1024x32 RAM with
//   byte enables and a registered-address read. At most one access per
//   cycle is issued; reads come back through a 2-stage tag pipeline with a
//   per-port readdatavalid strobe.
//
// Ports
//   clk, reset           rising-edge clock, async active-high reset
//   freeze               blocks new grants, in-flight reads keep draining
//   mN_*  (N = 0,1)      Avalon-MM slave side: address, byteenable, read,
//                        write, writedata in; waitrequest, readdata,
//                        readdatavalid out
//   ram_*                RAM slave port: address, byteenable, chipselect,
//                        write, writedata, clken out; readdata in

// Per-port read-return register. Captures RAM q when the stage-1 tag points
// at this port; the valid strobe is just the stage-2 tag match.
module ram1_arbiter_port #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic              hit,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        readdata <= '0;
        else if (capture) readdata <= ram_readdata;
    end

    assign readdatavalid = hit;
endmodule

module ram1_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                freeze,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);
    localparam int BE_W      = DATA_W / 8;
    localparam int NUM_PORTS = 2;
    localparam int STAGES    = 2;

    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
    logic [NUM_PORTS-1:0][BE_W-1:0]   be;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;
    logic [NUM_PORTS-1:0]             rd, wr, req, grant, rvalid;

    assign addr  = {m1_address, m0_address};
    assign be    = {m1_byteenable, m0_byteenable};
    assign wdata = {m1_writedata, m0_writedata};
    assign rd    = {m1_read, m0_read};
    assign wr    = {m1_write, m0_write};
    assign req   = rd | wr;

    // last_grant = 1 means m1 won most recently, so m0 wins the next tie.
    logic last_grant;
    logic sel;
    logic rd_issue;

    // Reset is folded in so waitrequest is forced high while reset is held.
    always_comb begin
        grant = '0;
        if (!reset && !freeze) begin
            if (&req) grant = last_grant ? 2'b01 : 2'b10;
            else      grant = req;
        end
    end

    // sel stays 0 when idle, so the RAM bus shows m0's values.
    assign sel = grant[1];

    assign m0_waitrequest = ~grant[0];
    assign m1_waitrequest = ~grant[1];

    assign ram_address    = addr[sel];
    assign ram_byteenable = be[sel];
    assign ram_writedata  = wdata[sel];
    assign ram_chipselect = |grant;
    assign ram_write      = (|grant) & wr[sel];
    assign ram_clken      = 1'b1;

    // read+write together is a write: no response tag.
    assign rd_issue = (|grant) & rd[sel] & ~wr[sel];

    // Stage 1: RAM has the address, q valid this cycle.
    // Stage 2: data sits in the port register, valid strobe out.
    logic [STAGES:1] vld_pipe;
    logic [STAGES:1] port_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            vld_pipe   <= '0;
            port_pipe  <= '0;
        end else begin
            if (|grant) last_grant <= sel;
            vld_pipe  <= {vld_pipe[STAGES-1:1], rd_issue};
            port_pipe <= {port_pipe[STAGES-1:1], sel};
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        ram1_arbiter_port #(.DATA_W(DATA_W)) u_port (
            .clk          (clk),
            .reset        (reset),
            .capture      (vld_pipe[1] & (port_pipe[1] == 1'(i))),
            .hit          (vld_pipe[STAGES] & (port_pipe[STAGES] == 1'(i))),
            .ram_readdata (ram_readdata),
            .readdata     (rdata[i]),
            .readdatavalid(rvalid[i])
        );
    end

    assign m0_readdata      = rdata[0];
    assign m1_readdata      = rdata[1];
    assign m0_readdatavalid = rvalid[0];
    assign m1_readdatavalid = rvalid[1];
endmodule

// File: tb/tb_ram1_arbiter.sv
module tb_ram1_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic [9:0]  m0_address = '0, m1_address = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [9:0]  ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata, ram_readdata;

    ram1_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset(rst), .freeze(freeze),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // RAM device: address registered on the clock, q read from the array.
    logic [31:0] ram [0:1023];
    logic [9:0]  ram_areg = '0;
    initial for (int i = 0; i < 1024; i++) ram[i] = init_val(i);
    always @(posedge clk) begin
        if (ram_clken) begin
            if (ram_chipselect && ram_write)
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) ram[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
            ram_areg <= ram_address;
        end
    end
    assign ram_readdata = ram[ram_areg];

    // ---------------- reference model ----------------
    int vectors = 0;
    int errors  = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // -1 none, 0 m0, 1 m1; last = 1 means m1 won most recently.
    function automatic int pick(bit r0, bit r1, bit frz, bit rs, bit last);
        if (rs || frz) return -1;
        if (r0 && r1) return last ? 0 : 1;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    typedef struct { int port; logic [31:0] data; int due; } rsp_t;
    rsp_t        pend[$];
    logic [31:0] shadow [0:1023];
    logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
    bit          lastg = 1'b1;
    int          cyc = 0;

    initial for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lastg = 1'b1;
            pend.delete();
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end else begin
            int g;
            cyc++;
            while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
            foreach (pend[k]) if (pend[k].due == cyc) exp_rd[pend[k].port] = pend[k].data;
            g = pick(m0_read | m0_write, m1_read | m1_write, freeze, 1'b0, lastg);
            if (g >= 0) begin
                logic        w, r;
                logic [9:0]  a;
                logic [3:0]  be;
                logic [31:0] d;
                lastg = (g == 1);
                w  = g ? m1_write      : m0_write;
                r  = g ? m1_read       : m0_read;
                a  = g ? m1_address    : m0_address;
                be = g ? m1_byteenable : m0_byteenable;
                d  = g ? m1_writedata  : m0_writedata;
                if (w) begin
                    for (int b = 0; b < 4; b++) if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
                end else if (r) begin
                    pend.push_back('{g, shadow[a], cyc + 1});
                end
            end
        end
    end

    // Every-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        int g;
        bit v0, v1;
        g = pick(m0_read | m0_write, m1_read | m1_write, freeze, rst, lastg);
        v0 = 0; v1 = 0;
        foreach (pend[k]) if (pend[k].due == cyc) begin
            if (pend[k].port == 0) v0 = 1; else v1 = 1;
        end
        chk("m0_waitrequest", 32'(m0_waitrequest), 32'(g != 0));
        chk("m1_waitrequest", 32'(m1_waitrequest), 32'(g != 1));
        chk("ram_chipselect", 32'(ram_chipselect), 32'(g >= 0));
        chk("ram_write", 32'(ram_write),
            32'(g == 0 ? m0_write : g == 1 ? m1_write : 1'b0));
        chk("ram_address", 32'(ram_address), 32'(g == 1 ? m1_address : m0_address));
        chk("ram_byteenable", 32'(ram_byteenable), 32'(g == 1 ? m1_byteenable : m0_byteenable));
        chk("ram_writedata", ram_writedata, g == 1 ? m1_writedata : m0_writedata);
        chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(v0));
        chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(v1));
        chk("m0_readdata", m0_readdata, exp_rd[0]);
        chk("m1_readdata", m1_readdata, exp_rd[1]);
    end

    // m1 response log for the back-to-back ordering check.
    typedef struct { int n; logic [31:0] d; } log_t;
    log_t m1_log[$];
    int   ncyc = 0;
    always @(negedge clk) begin
        ncyc++;
        if (m1_readdatavalid) m1_log.push_back('{ncyc, m1_readdata});
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive(int p, bit r, bit w, logic [9:0] a, logic [3:0] be, logic [31:0] d);
        if (p == 0) begin
            m0_read = r; m0_write = w; m0_address = a; m0_byteenable = be; m0_writedata = d;
        end else begin
            m1_read = r; m1_write = w; m1_address = a; m1_byteenable = be; m1_writedata = d;
        end
    endtask

    // Holds the request until accepted; returns 1ns after the accepting edge.
    task automatic xfer(int p, bit r, bit w, logic [9:0] a, logic [3:0] be, logic [31:0] d);
        bit ok = 0;
        drive(p, r, w, a, be, d);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = !(p == 0 ? m0_waitrequest : m1_waitrequest);
        end
        if (!ok) begin
            errors++;
            $display("FAIL xfer_timeout: port %0d never accepted", p);
        end
        step();
        drive(p, 0, 0, '0, '0, '0);
    endtask

    initial begin
        bit act [2] = '{0, 0};
        bit acc [2] = '{0, 0};

        // Reset state
        step();
        chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("rst_m0_rd", m0_readdata, 32'h0);
        chk("rst_cs", 32'(ram_chipselect), 32'd0);
        step();
        rst = 0;
        step();

        // Single write then read on m0
        xfer(0, 0, 1, 10'd5, 4'hF, 32'hDEADBEEF);
        xfer(0, 1, 0, 10'd5, 4'h0, 32'h0);
        @(negedge clk);
        chk("wr_rd_early_valid", 32'(m0_readdatavalid), 32'd0);
        @(negedge clk);
        chk("wr_rd_valid", 32'(m0_readdatavalid), 32'd1);
        chk("wr_rd_data", m0_readdata, 32'hDEADBEEF);
        chk("wr_rd_m1_valid", 32'(m1_readdatavalid), 32'd0);
        step();

        // Byte lanes
        xfer(0, 0, 1, 10'd7, 4'hF, 32'hFFFFFFFF);
        xfer(0, 0, 1, 10'd7, 4'h1, 32'h00000012);
        xfer(0, 1, 0, 10'd7, 4'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("byte_lane_valid", 32'(m0_readdatavalid), 32'd1);
        chk("byte_lane_data", m0_readdata, 32'hFFFFFF12);
        step();

        // Back-to-back m1 reads of preloaded words
        for (int i = 0; i < 4; i++) xfer(0, 0, 1, 10'(i), 4'hF, 32'h10 + 32'(i));
        m1_log.delete();
        for (int i = 0; i < 4; i++) xfer(1, 1, 0, 10'(i), 4'h0, 32'h0);
        repeat (4) step();
        chk("b2b_count", 32'(m1_log.size()), 32'd4);
        if (m1_log.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("b2b_data", m1_log[i].d, 32'h10 + 32'(i));
                chk("b2b_consecutive", 32'(m1_log[i].n - m1_log[0].n), 32'(i));
            end

        // Freeze with a read in flight; m0 was granted last
        xfer(0, 1, 0, 10'd5, 4'h0, 32'h0);
        freeze = 1;
        drive(0, 1, 0, 10'd1, 4'h0, 32'h0);
        drive(1, 1, 0, 10'd2, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("frz_m0_wait", 32'(m0_waitrequest), 32'd1);
            chk("frz_m1_wait", 32'(m1_waitrequest), 32'd1);
            if (k == 1) begin
                chk("frz_inflight_valid", 32'(m0_readdatavalid), 32'd1);
                chk("frz_inflight_data", m0_readdata, 32'hDEADBEEF);
            end
            step();
        end
        freeze = 0;
        @(negedge clk);
        chk("unfrz_m1_wins", 32'(m1_waitrequest), 32'd0);
        chk("unfrz_m0_waits", 32'(m0_waitrequest), 32'd1);
        step();
        drive(1, 0, 0, '0, '0, '0);
        @(negedge clk);
        chk("unfrz_m0_next", 32'(m0_waitrequest), 32'd0);
        step();
        drive(0, 0, 0, '0, '0, '0);
        repeat (3) step();

        // Reset pulse right after a read is accepted
        xfer(0, 1, 0, 10'd5, 4'h0, 32'h0);
        rst = 1;
        step();
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(m0_readdatavalid), 32'd0);
            chk("post_rst_data", m0_readdata, 32'h0);
            step();
        end

        // Continuous contention from reset: m0, m1, m0, ...
        drive(0, 1, 0, 10'd5, 4'h0, 32'h0);
        drive(1, 1, 0, 10'd7, 4'h0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("contend_m0_wait", 32'(m0_waitrequest), 32'(k % 2));
            step();
        end
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        repeat (3) step();

        // Random traffic; requests held until accepted
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!act[p] || acc[p]) begin
                    int kind;
                    kind = $urandom_range(0, 9);
                    act[p] = (kind >= 3);
                    drive(p, act[p] && kind != 9 ? kind[0] | (kind == 8) : 0,
                          act[p] && (!kind[0] || kind == 9),
                          10'($urandom_range(0, 15)), 4'($urandom), $urandom);
                end
            end
            freeze = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            acc[0] = act[0] && !m0_waitrequest;
            acc[1] = act[1] && !m1_waitrequest;
            step();
        end
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        freeze = 0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
